// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_arb_entry_t;

  function automatic logic [XLEN-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    rd_onehot     = '0;
    rd_onehot[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// Circular buffer of multicycle results with squash-by-rd and a pending-destination mask.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  input  logic                  squash_en,
  input  logic [REG_ADDR_W-1:0] squash_rd,
  output logic [CNT_W-1:0]      count,
  output rf_arb_entry_t         head,
  output logic [XLEN-1:0]       busy_mask
);

  localparam int PTR_W = $clog2(DEPTH);

  logic                  vld_q  [DEPTH];
  logic                  vld_d  [DEPTH];
  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [REG_ADDR_W-1:0] rd_d   [DEPTH];
  logic [XLEN-1:0]       data_q [DEPTH];
  logic [XLEN-1:0]       data_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  always_comb begin
    vld_d    = vld_q;
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // Squash only touches entries already held; a same-cycle push stays valid.
    if (squash_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (rd_q[i] == squash_rd)) vld_d[i] = 1'b0;
      end
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      vld_d[wr_ptr_q]  = 1'b1;
      rd_d[wr_ptr_q]   = push_rd;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q    <= '{default: 1'b0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) busy_mask = busy_mask | rd_onehot(rd_q[i]);
    end
    busy_mask[0] = 1'b0;
  end

  assign count      = count_q;
  assign head.valid = vld_q[rd_ptr_q];
  assign head.rd    = rd_q[rd_ptr_q];
  assign head.data  = data_q[rd_ptr_q];

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback (always wins) and the multicycle unit.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_rd,
  input  logic [XLEN-1:0]       mc_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  stall_req,
  output logic [XLEN-1:0]       busy_mask
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  logic                  wb_valid, mc_acc, mc_keep, push, pop;
  logic [CNT_W-1:0]      count;
  rf_arb_entry_t         head;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic                  stall_req_q, stall_req_d;
  logic [ST_W-1:0]       starve_q, starve_d;

  assign wb_valid = wb_reg_write && (wb_rd != '0);
  // Registered count only: a full buffer refuses even when it pops this cycle.
  assign mc_ready = !reset && (int'(count) < DEPTH);
  assign mc_acc   = mc_valid && mc_ready;
  assign mc_keep  = mc_acc && (mc_rd != '0);

  rf_arb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_rd   (mc_rd),
    .push_data (mc_data),
    .pop       (pop),
    .squash_en (wb_valid),
    .squash_rd (wb_rd),
    .count     (count),
    .head      (head),
    .busy_mask (busy_mask)
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    push       = 1'b0;
    pop        = 1'b0;
    starve_d   = starve_q;
    if (wb_valid) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
      push       = mc_keep;
      if ((count != '0) && (int'(starve_q) < STARVE_LIMIT)) starve_d = starve_q + ST_W'(1);
    end else if (count != '0) begin
      // A squashed head still consumes its slot but writes nothing.
      rf_we_d    = head.valid;
      rf_waddr_d = head.rd;
      rf_wdata_d = head.data;
      pop        = 1'b1;
      push       = mc_keep;
      starve_d   = '0;
    end else if (mc_keep) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mc_rd;
      rf_wdata_d = mc_data;
    end
    stall_req_d = (count != '0) && (int'(starve_q) >= STARVE_LIMIT - 1) && wb_valid;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      stall_req_q <= 1'b0;
      starve_q    <= '0;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      stall_req_q <= stall_req_d;
      starve_q    <= starve_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign stall_req = stall_req_q;

endmodule
